// File: rtl/uart_cmd_pkg.sv
// Command codes, master FSM encoding and read/write command decode shared by the UART command master.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_SYS_RESET = 8'h10;
  localparam logic [7:0] CMD_SYS_START = 8'h11;
  localparam logic [7:0] CMD_SYS_STOP  = 8'h12;
  localparam logic [7:0] CMD_SYS_CLEAR = 8'h13;
  // Banked commands: the low three bits select one of eight targets.
  localparam logic [7:0] CMD_RD_REG    = 8'h20;
  localparam logic [7:0] CMD_WR_REG    = 8'h30;
  localparam logic [7:0] CMD_WR_MEM    = 8'h40;
  localparam logic [7:0] CMD_RD_MEM    = 8'h50;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_CMD,
    ST_SEND_DATA,
    ST_WAIT_RSP,
    ST_DONE
  } state_t;

  function automatic logic is_read(input logic [7:0] cmd);
    return (cmd[7:3] == CMD_RD_REG[7:3]) || (cmd[7:3] == CMD_RD_MEM[7:3]);
  endfunction

endpackage

// File: rtl/uart_byte_phy.sv
// 8N1 byte serializer/deserializer; tx_busy drops in the last stop-bit cycle so a new byte follows gaplessly.
// RX: two-flop sync, start-bit recheck at midpoint, rx_valid pulses at the stop-bit midpoint with rx_ferr.
module uart_byte_phy #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx_busy,
  output logic       uart_txd,
  input  logic       uart_rxd,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_ferr
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

  logic          tx_active;
  logic [CW-1:0] tx_clk;
  logic [3:0]    tx_bit;
  logic [9:0]    tx_frame;
  logic          tx_last;

  assign tx_last  = tx_active && (tx_bit == 4'd9) && (tx_clk == BIT_LAST);
  assign tx_busy  = tx_active && !tx_last;
  assign uart_txd = tx_active ? tx_frame[0] : 1'b1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_active <= 1'b0;
      tx_clk    <= '0;
      tx_bit    <= '0;
      tx_frame  <= '0;
    end else if (tx_start && !tx_busy) begin
      tx_active <= 1'b1;
      tx_clk    <= '0;
      tx_bit    <= '0;
      tx_frame  <= {1'b1, tx_byte, 1'b0};
    end else if (tx_active) begin
      if (tx_clk == BIT_LAST) begin
        tx_clk   <= '0;
        tx_frame <= {1'b1, tx_frame[9:1]};
        if (tx_bit == 4'd9) tx_active <= 1'b0;
        else                tx_bit    <= tx_bit + 4'd1;
      end else begin
        tx_clk <= tx_clk + CW'(1);
      end
    end
  end

  logic          rx_s1, rx_s2, rx_s3;
  logic          rx_active;
  logic [CW-1:0] rx_clk;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_sh;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_s3     <= 1'b1;
      rx_active <= 1'b0;
      rx_clk    <= '0;
      rx_bit    <= '0;
      rx_sh     <= '0;
      rx_valid  <= 1'b0;
      rx_byte   <= '0;
      rx_ferr   <= 1'b0;
    end else begin
      rx_s1    <= uart_rxd;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_valid <= 1'b0;
      if (!rx_active) begin
        if (rx_s3 && !rx_s2) begin
          rx_active <= 1'b1;
          rx_clk    <= '0;
          rx_bit    <= '0;
        end
      end else begin
        rx_clk <= (rx_clk == BIT_LAST) ? '0 : rx_clk + CW'(1);
        if (rx_clk == BIT_MID) begin
          if (rx_bit == 4'd0) begin
            // Line back high at the start-bit midpoint: treat as a glitch.
            if (rx_s2) rx_active <= 1'b0;
            else       rx_bit    <= 4'd1;
          end else if (rx_bit == 4'd9) begin
            rx_valid  <= 1'b1;
            rx_ferr   <= !rx_s2;
            rx_byte   <= rx_sh;
            rx_active <= 1'b0;
          end else begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_bit <= rx_bit + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/uart_cmd_master.sv
// Sends a command byte and a data byte over UART, waits for one reply byte on reads, then pulses rsp_valid.
// Write latency 20*CLKS_PER_BIT+2 cycles; req_ready only in IDLE. UART_CMD_MASTER_TIMEOUT_EN bounds the reply wait.
module uart_cmd_master
  import uart_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 434,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_cmd,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       uart_txd,
  input  logic       uart_rxd
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t     state, state_nxt;
  logic       armed;
  logic [7:0] cmd_q, data_q;
  logic       data_sent;
  logic [7:0] done_data, res_data;
  logic       done_err, res_err;
  logic       tx_start, tx_busy;
  logic [7:0] tx_byte;
  logic       rx_valid, rx_ferr;
  logic [7:0] rx_byte;

  uart_byte_phy #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_phy (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .tx_start (tx_start),
    .tx_byte  (tx_byte),
    .tx_busy  (tx_busy),
    .uart_txd (uart_txd),
    .uart_rxd (uart_rxd),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .rx_ferr  (rx_ferr)
  );

`ifdef UART_CMD_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          to_hit;
  assign to_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)               to_cnt <= '0;
    else if (state == ST_WAIT_RSP) to_cnt <= to_cnt + TW'(1);
    else                           to_cnt <= '0;
  end
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_data = 8'h00;
    done_err  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          if (req_cmd == 8'h00) begin
            state_nxt = ST_DONE;
            done_err  = 1'b1;
          end else begin
            state_nxt = ST_SEND_CMD;
          end
        end
      end
      ST_SEND_CMD:  if (!tx_busy) state_nxt = ST_SEND_DATA;
      ST_SEND_DATA: begin
        // The data byte is on the line once data_sent is set; leave in its final stop-bit cycle.
        if (data_sent && !tx_busy) state_nxt = is_read(cmd_q) ? ST_WAIT_RSP : ST_DONE;
      end
      ST_WAIT_RSP: begin
        if (rx_valid) begin
          state_nxt = ST_DONE;
          done_data = rx_ferr ? 8'h00 : rx_byte;
          done_err  = rx_ferr;
        end
`ifdef UART_CMD_MASTER_TIMEOUT_EN
        else if (to_hit) begin
          state_nxt = ST_DONE;
          done_err  = 1'b1;
        end
`endif
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = armed && (state == ST_IDLE);
    tx_start  = 1'b0;
    tx_byte   = data_q;
    if (state == ST_SEND_CMD) begin
      tx_start = !tx_busy;
      tx_byte  = cmd_q;
    end else if (state == ST_SEND_DATA) begin
      tx_start = !data_sent && !tx_busy;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      armed     <= 1'b0;
      cmd_q     <= '0;
      data_q    <= '0;
      data_sent <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      armed     <= 1'b1;
      data_sent <= (state == ST_SEND_DATA) && (data_sent || tx_start);
      rsp_valid <= (state == ST_DONE);
      if (state == ST_IDLE && req_valid && req_ready) begin
        cmd_q  <= req_cmd;
        data_q <= req_data;
      end
      if (state_nxt == ST_DONE) begin
        res_data <= done_data;
        res_err  <= done_err;
      end
      if (state == ST_DONE) begin
        rsp_data <= res_data;
        rsp_err  <= res_err;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Directed bench for uart_cmd_master at CLKS_PER_BIT=4, TIMEOUT_CYCLES=200.
// Cycle index m = interval [E0+m, E0+m+1) after the acceptance edge E0, sampled on the falling edge.
module tb_uart_cmd_master;

  localparam int CPB = 4;
  localparam int TO  = 200;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_cmd;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       uart_txd;
  logic       uart_rxd;

  always #5 sys_clk = ~sys_clk;

  uart_cmd_master #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_cmd  (req_cmd),
    .req_data (req_data),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .uart_txd (uart_txd),
    .uart_rxd (uart_rxd)
  );

  int         total = 0;
  int         bad   = 0;
  int         cyc_n = 0;
  int         rv_cnt = 0;
  int         rv_at  = -1;
  logic [7:0] rv_d   = 8'h00;
  logic       rv_e   = 1'b0;
  logic       tl [0:2047];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge sys_clk);
    cyc_n++;
    if (cyc_n >= 0 && cyc_n < 2048) tl[cyc_n] = uart_txd;
    if (rsp_valid) begin
      rv_cnt++;
      rv_at = cyc_n;
      rv_d  = rsp_data;
      rv_e  = rsp_err;
    end
  endtask

  // Present a request for one cycle; cyc_n becomes 0 in the cycle after the acceptance edge.
  task automatic issue(input logic [7:0] c, input logic [7:0] d);
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_cmd   = c;
    req_data  = d;
    req_valid = 1'b1;
    cyc_n  = -1;
    rv_cnt = 0;
    rv_at  = -1;
    cyc();
    req_valid = 1'b0;
    req_cmd   = 8'hFF;
    req_data  = 8'h00;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    for (int j = 0; j < 10; j++) begin
      uart_rxd = (j == 0) ? 1'b0 : (j == 9) ? stop : b[j-1];
      repeat (CPB) cyc();
    end
    uart_rxd = 1'b1;
  endtask

  // Frame whose start bit begins at cycle s: bits sampled mid-bit.
  function automatic logic [7:0] dec(input int s);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = tl[s + 1 + CPB * (i + 1)];
    return r;
  endfunction

  function automatic int ones(input int a, input int b);
    int n;
    n = 0;
    for (int i = a; i <= b; i++) if (tl[i] === 1'b1) n++;
    return n;
  endfunction

  initial begin
    sys_rst_n = 1'b0;
    req_valid = 1'b0;
    req_cmd   = 8'h00;
    req_data  = 8'h00;
    uart_rxd  = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("rst_txd",       32'(uart_txd),  32'd1);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",  32'(rsp_data),  32'h00);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Write 0x31/0xA5; inputs change right after acceptance and must not matter.
    issue(8'h31, 8'hA5);
    while (cyc_n < 90) cyc();
    chk("wr_idle_accept_cyc", 32'(tl[0]), 32'd1);
    chk("wr_cmd_start",       32'(tl[1]), 32'd0);
    chk("wr_cmd_byte",        32'(dec(1)), 32'h31);
    chk("wr_cmd_stop",        32'(tl[40]), 32'd1);
    chk("wr_data_start_gap0", 32'(tl[41]), 32'd0);
    chk("wr_data_byte",       32'(dec(41)), 32'hA5);
    chk("wr_data_stop",       32'(tl[80]), 32'd1);
    chk("wr_idle_after",      32'(ones(81, 90)), 32'd10);
    chk("wr_rsp_count",       32'(rv_cnt), 32'd1);
    chk("wr_rsp_latency",     32'(rv_at), 32'd82);
    chk("wr_rsp_err",         32'(rv_e), 32'd0);
    chk("wr_rsp_data",        32'(rv_d), 32'h00);

    // A byte arriving while the command is still being sent is dropped.
    issue(8'h10, 8'h00);
    rx_frame(8'h77, 1'b1);
    while (cyc_n < 90) cyc();
    chk("disc_rsp_count",   32'(rv_cnt), 32'd1);
    chk("disc_rsp_latency", 32'(rv_at), 32'd82);
    chk("disc_rsp_data",    32'(rv_d), 32'h00);
    chk("disc_rsp_err",     32'(rv_e), 32'd0);

    // Read 0x22: both bytes sent, reply 0x5C after the data byte.
    issue(8'h22, 8'h07);
    while (cyc_n < 81) cyc();
    chk("rd_cmd_byte",  32'(dec(1)), 32'h22);
    chk("rd_data_byte", 32'(dec(41)), 32'h07);
    chk("rd_no_early_rsp", 32'(rv_cnt), 32'd0);
    rx_frame(8'h5C, 1'b1);
    repeat (20) cyc();
    chk("rd_rsp_count", 32'(rv_cnt), 32'd1);
    chk("rd_rsp_data",  32'(rv_d), 32'h5C);
    chk("rd_rsp_err",   32'(rv_e), 32'd0);
    chk("rd_data_held", 32'(rsp_data), 32'h5C);
    chk("rd_valid_low", 32'(rsp_valid), 32'd0);

    // Command 0x00 is rejected without touching the line.
    issue(8'h00, 8'h99);
    repeat (9) cyc();
    chk("nul_rsp_count", 32'(rv_cnt), 32'd1);
    chk("nul_rsp_at",    32'(rv_at), 32'd1);
    chk("nul_rsp_err",   32'(rv_e), 32'd1);
    chk("nul_rsp_data",  32'(rv_d), 32'h00);
    chk("nul_line_idle", 32'(ones(0, 9)), 32'd10);

    // Reply with a low stop bit is a framing error.
    issue(8'h25, 8'h00);
    while (cyc_n < 81) cyc();
    rx_frame(8'hA3, 1'b0);
    repeat (20) cyc();
    chk("ferr_rsp_count", 32'(rv_cnt), 32'd1);
    chk("ferr_rsp_err",   32'(rv_e), 32'd1);
    chk("ferr_rsp_data",  32'(rv_d), 32'h00);

    // One-cycle low glitch is ignored; a later clean byte completes the read.
    issue(8'h53, 8'h11);
    while (cyc_n < 81) cyc();
    uart_rxd = 1'b0;
    cyc();
    uart_rxd = 1'b1;
    repeat (20) cyc();
    chk("glitch_no_rsp", 32'(rv_cnt), 32'd0);
    rx_frame(8'h3C, 1'b1);
    repeat (20) cyc();
    chk("glitch_rsp_count", 32'(rv_cnt), 32'd1);
    chk("glitch_rsp_data",  32'(rv_d), 32'h3C);
    chk("glitch_rsp_err",   32'(rv_e), 32'd0);

    // Read 0x50 with no reply.
    issue(8'h50, 8'h00);
`ifdef UART_CMD_MASTER_TIMEOUT_EN
    while (cyc_n < 300) cyc();
    chk("to_rsp_count", 32'(rv_cnt), 32'd1);
    chk("to_rsp_at",    32'(rv_at), 32'd282);
    chk("to_rsp_err",   32'(rv_e), 32'd1);
    chk("to_rsp_data",  32'(rv_d), 32'h00);
`else
    while (cyc_n < 1000) cyc();
    chk("noto_no_rsp",  32'(rv_cnt), 32'd0);
    chk("noto_not_ready", 32'(req_ready), 32'd0);
`endif
    sys_rst_n = 1'b0;
    repeat (2) cyc();
    sys_rst_n = 1'b1;
    cyc();

    // Reset during the data byte (data 0x34, bit 1 is low at cycle 50).
    issue(8'h12, 8'h34);
    while (cyc_n < 50) cyc();
    chk("mid_txd_low_before", 32'(uart_txd), 32'd0);
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_txd",       32'(uart_txd),  32'd1);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    repeat (3) cyc();
    sys_rst_n = 1'b1;
    rv_cnt = 0;
    cyc();
    chk("mid_ready_after", 32'(req_ready), 32'd1);
    cyc_n = 0;
    repeat (100) cyc();
    chk("mid_no_rsp",    32'(rv_cnt), 32'd0);
    chk("mid_line_idle", 32'(ones(1, 100)), 32'd100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_master.md
UART_CMD_MASTER -- requirements
Module: uart_cmd_master

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, sys_clk cycles per serial bit (50 MHz / 115200).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, maximum wait for a response byte.
REQ-003 SHALL have port sys_clk  in  1  clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req_valid  in  1, req_ready  out  1, req_cmd  in  8, req_data  in  8: command request handshake.
REQ-006 SHALL have ports rsp_valid  out  1, rsp_data  out  8, rsp_err  out  1: completion pulse, read byte, error flag.
REQ-007 SHALL have ports uart_txd  out  1 and uart_rxd  in  1: serial line, 8N1, LSB first, idle high.

Function
REQ-008 SHALL accept a request when req_valid and req_ready are both high on a rising edge; req_ready SHALL be high only in IDLE.
REQ-009 SHALL latch req_cmd/req_data on acceptance; later input changes SHALL not affect the transaction.
REQ-010 SHALL use states IDLE -> SEND_CMD -> SEND_DATA -> (WAIT_RSP if read command) -> DONE -> IDLE.
REQ-011 SHALL classify a command as a read when it is 0x20-0x27 or 0x50-0x57; all other non-zero codes are writes.
REQ-012 SHALL reject req_cmd == 0x00 without touching the line: IDLE -> DONE with rsp_err=1, rsp_data=0.
REQ-013 SHALL transmit the command byte, then the data byte, with no idle bit time between them; both bytes are always sent, including for reads.
REQ-014 SHALL frame each byte as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit exactly CLKS_PER_BIT cycles.
REQ-015 SHALL start WAIT_RSP on the cycle after the data byte's stop bit completes.
REQ-016 SHALL synchronize uart_rxd through two flops, detect a falling edge as a start bit, and sample each bit at its midpoint.
REQ-017 SHALL recheck the start bit at its midpoint; if high, it is a glitch and the receiver returns to idle.
REQ-018 SHALL treat a stop bit sampled low as a framing error; in WAIT_RSP this completes the transaction with rsp_err=1.
REQ-019 SHALL discard received bytes outside WAIT_RSP silently.
REQ-020 SHALL in DONE drive rsp_valid high for exactly one cycle with rsp_data (read byte, else 0x00) and rsp_err, then return to IDLE.
REQ-021 SHALL hold rsp_data/rsp_err stable until the next completion; rsp_valid low otherwise.
REQ-022 SHALL have latency from acceptance to rsp_valid, for a write, of exactly 20*CLKS_PER_BIT+2 cycles.
REQ-023 SHALL keep uart_txd high whenever not transmitting.

Reset
REQ-024 SHALL on sys_rst_n low immediately force IDLE, uart_txd=1, req_ready=0, rsp_valid=0, rsp_data=0x00, rsp_err=0, and clear all counters and shift registers.
REQ-025 SHALL drive req_ready=1 on the first clock after reset release; reset mid-frame truncates the frame with no completion pulse.

Configuration
REQ-026 SHALL, with UART_CMD_MASTER_TIMEOUT_EN defined, count cycles in WAIT_RSP and complete with rsp_err=1, rsp_data=0x00 on reaching TIMEOUT_CYCLES.
REQ-027 SHALL, without UART_CMD_MASTER_TIMEOUT_EN, wait in WAIT_RSP indefinitely (until a byte or a framing error) and omit the timeout counter.

Structure
REQ-028 SHALL place command code constants (0x10-0x13, 0x20-0x27, 0x30-0x37, 0x40-0x47, 0x50-0x57), the state encoding and the is-read decode function in package uart_cmd_pkg.
REQ-029 SHALL implement bit timing, TX serializer and RX deserializer in one sub-module uart_byte_phy (tx_start/tx_byte/tx_busy, rx_valid/rx_byte/rx_ferr).

Verification (CLKS_PER_BIT=4, TIMEOUT_CYCLES=200)
REQ-030 SHALL check: write cmd 0x31 data 0xA5 -> line carries 0x31 then 0xA5, 8N1; rsp_valid one cycle at 82 cycles, rsp_err=0, rsp_data=0x00.
REQ-031 SHALL check: read cmd 0x22 with model replying 0x5C after the data byte -> rsp_valid, rsp_data=0x5C, rsp_err=0.
REQ-032 SHALL check: cmd 0x00 -> no line activity, rsp_valid next-but-one cycle with rsp_err=1.
REQ-033 SHALL check: read 0x50 with no reply -> with macro, rsp_err=1 after 200 WAIT_RSP cycles; without macro, no rsp_valid within 1000 cycles.
REQ-034 SHALL check: reply byte with stop bit 0 -> rsp_err=1; a 1-cycle low glitch on uart_rxd -> ignored.
REQ-035 SHALL check: reset asserted mid data byte -> uart_txd=1 immediately, no rsp_valid, req_ready=1 after release.
